// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: byte-wide memory read port, decoder-facing
// instruction outputs and the execute-stage retire/branch inputs.
//   master : the fetch unit (drives mem_req/mem_addr and the inst outputs)
//   slave  : memory + decoder + execute environment
interface fetch_unit_if;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned INST_W = 16;

  // memory read port
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [BYTE_W-1:0] mem_rdata;

  // decoder side
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [BYTE_W-1:0] data;
  logic [ADDR_W-1:0] inst_pc;

  // execute side
  logic              exec_done;
  logic              branch_take;
  logic [ADDR_W-1:0] branch_target;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, data, inst_pc,
    input  mem_ack, mem_rdata, exec_done, branch_take, branch_target
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, data, inst_pc,
    output mem_ack, mem_rdata, exec_done, branch_take, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage of the 16-bit CPU.
// Reads the opcode byte, an optional argument byte and, for
// immediate-from-data instructions, a data byte from zero page, then holds
// {opcode, argument}, data and the opcode address for the decoder until
// execute retires the instruction and supplies the next PC.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (master)      : mem_req/mem_addr/mem_ack/mem_rdata memory port,
//                       inst_valid/inst/data/inst_pc to decoder,
//                       exec_done/branch_take/branch_target from execute
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned INST_W = 16;

  typedef enum logic [1:0] {
    FETCH_OP   = 2'd0,
    FETCH_ARG  = 2'd1,
    FETCH_DATA = 2'd2,
    READY      = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [BYTE_W-1:0] op;
  logic [INST_W-1:0] inst_q;
  logic [BYTE_W-1:0] data_q;

  logic              data_src_c;
  logic [ADDR_W-1:0] seq_pc_c;
  logic [ADDR_W-1:0] addr_c;

  // Immediate-from-data source: class 2'b10 with source field 2'b01.
  assign data_src_c = (op[7:6] == 2'b10) && (op[2:1] == 2'b01);

  // Sequential successor: opcodes with bit 7 set carry an argument byte.
  assign seq_pc_c = op[7] ? ADDR_W'(pc + ADDR_W'(2)) : ADDR_W'(pc + ADDR_W'(1));

  // Request address is a pure decode of held registers, so it cannot move
  // while a request is outstanding.
  always_comb begin
    addr_c = pc;
    unique case (state)
      FETCH_OP:   addr_c = pc;
      FETCH_ARG:  addr_c = ADDR_W'(pc + ADDR_W'(1));
      FETCH_DATA: addr_c = {8'h00, inst_q[7:0]};
      READY:      addr_c = pc;
      default:    addr_c = pc;
    endcase
  end

  // Fetch sequencer; transfers are only accepted in the FETCH states, so an
  // ack during READY falls through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FETCH_OP;
      pc     <= RESET_PC;
      op     <= '0;
      inst_q <= '0;
      data_q <= '0;
    end else begin
      unique case (state)
        FETCH_OP: begin
          if (bus.mem_ack) begin
            op <= bus.mem_rdata;
            if (!bus.mem_rdata[7]) begin
              inst_q <= {bus.mem_rdata, 8'h00};
              data_q <= '0;
              state  <= READY;
            end else begin
              state  <= FETCH_ARG;
            end
          end
        end
        FETCH_ARG: begin
          if (bus.mem_ack) begin
            inst_q <= {op, bus.mem_rdata};
            if (data_src_c) begin
              state  <= FETCH_DATA;
            end else begin
              data_q <= '0;
              state  <= READY;
            end
          end
        end
        FETCH_DATA: begin
          if (bus.mem_ack) begin
            data_q <= bus.mem_rdata;
            state  <= READY;
          end
        end
        READY: begin
          if (bus.exec_done) begin
            pc    <= bus.branch_take ? bus.branch_target : seq_pc_c;
            state <= FETCH_OP;
          end
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

  // pc only moves on retirement, so it doubles as the held opcode address.
  assign bus.mem_req    = (state != READY);
  assign bus.mem_addr   = addr_c;
  assign bus.inst_valid = (state == READY);
  assign bus.inst       = inst_q;
  assign bus.data       = data_q;
  assign bus.inst_pc    = pc;

endmodule
